fp32_result_serializer: RTL and testbench

- Receiving end of the FP32 MAC result interface.
- Captures the 32-bit MAC result (delta) on each new MAC_VALID rising edge and drives MAC_READY back to the MAC.
- Serializes the captured word into bytes on a valid/ready byte stream feeding the UART transmitter.
- Sits between the MAC and the tx block in the rx→mac→tx chain.

---
 rtl/fp32_result_serializer.sv | 117 +++++++++++
 tb/tb_fp32_result_serializer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_result_serializer.sv
// Receives FP32 MAC results on a level-valid edge and streams each one as a
// byte frame (optional header, then four data bytes) on a valid/ready link.
module fp32_result_serializer #(
  parameter bit         MSB_FIRST   = 1'b1,
  parameter bit         HEADER_EN   = 1'b0,
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input  logic        CLK_I,
  input  logic        RSTL_I,
  input  logic        MAC_VALID_I,
  input  logic [31:0] DELTA_I,
  output logic        MAC_READY_O,
  output logic [7:0]  TX_DATA_O,
  output logic        TX_VALID_O,
  input  logic        TX_READY_I,
  output logic        BUSY_O,
  output logic        OVERRUN_O
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_e;

  localparam int unsigned FRAME_LEN = 4 + (HEADER_EN ? 1 : 0);
  localparam logic [2:0]  LAST_IDX  = 3'(FRAME_LEN - 1);

  state_e      state_q, state_d;
  logic [31:0] shadow_q, shadow_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        overrun_q, overrun_d;
  logic        valid_q;
  logic        new_result;
  logic        tx_fire;

  // Byte at frame position idx: header first when enabled, then data lanes.
  function automatic logic [7:0] frame_byte(input logic [31:0] word,
                                            input logic [2:0]  idx);
    logic [1:0] lane;
    logic [7:0] b;
    lane = idx[1:0] - (HEADER_EN ? 2'd1 : 2'd0);
    if (MSB_FIRST) lane = 2'd3 - lane;
    b = word[8*lane +: 8];
    if (HEADER_EN && idx == 3'd0) b = HEADER_BYTE;
    return b;
  endfunction

  assign new_result = MAC_VALID_I & ~valid_q;
  assign tx_fire    = tx_valid_q & TX_READY_I;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the shadow word is reset too, as it is a plain
  // register rather than a memory array.
  always_ff @(posedge CLK_I or negedge RSTL_I) begin
    if (!RSTL_I) begin
      state_q    <= S_IDLE;
      shadow_q   <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      overrun_q  <= overrun_d;
      valid_q    <= MAC_VALID_I;
    end
  end

  // NOTE: every comb output gets a hold default first, so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    overrun_d  = overrun_q | (new_result & (state_q != S_IDLE));
    unique case (state_q)
      S_IDLE: begin
        if (new_result) begin
          shadow_d   = DELTA_I;
          idx_d      = 3'd0;
          tx_data_d  = frame_byte(DELTA_I, 3'd0);
          tx_valid_d = 1'b1;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_fire) begin
          if (idx_q == LAST_IDX) begin
            tx_valid_d = 1'b0;
            state_d    = S_DONE;
          end else begin
            idx_d     = idx_q + 3'd1;
            tx_data_d = frame_byte(shadow_q, idx_q + 3'd1);
          end
        end
      end
      // One dead cycle guarantees a valid-low gap between frames.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    MAC_READY_O = (state_q == S_IDLE);
    BUSY_O      = (state_q == S_SEND);
  end

  assign TX_DATA_O  = tx_data_q;
  assign TX_VALID_O = tx_valid_q;
  assign OVERRUN_O  = overrun_q;

endmodule

// File: tb/tb_fp32_result_serializer.sv
// Bench for fp32_result_serializer: three configurations share one stimulus
// stream and are compared each cycle against a frame-level reference model.
module tb_fp32_result_serializer;

  localparam int NCFG = 3;  // 0: MSB first, 1: LSB first, 2: MSB first + header

  logic                 clk       = 1'b0;
  logic                 rst_n     = 1'b1;
  logic                 mac_valid = 1'b0;
  logic [31:0]          delta     = '0;
  logic                 tx_ready  = 1'b0;
  logic [NCFG-1:0]      mac_ready, tx_valid, busy, overrun;
  logic [NCFG-1:0][7:0] tx_data;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    fp32_result_serializer #(
      .MSB_FIRST  (g != 1),
      .HEADER_EN  (g == 2),
      .HEADER_BYTE(8'hA5)
    ) u_dut (
      .CLK_I      (clk),
      .RSTL_I     (rst_n),
      .MAC_VALID_I(mac_valid),
      .DELTA_I    (delta),
      .MAC_READY_O(mac_ready[g]),
      .TX_DATA_O  (tx_data[g]),
      .TX_VALID_O (tx_valid[g]),
      .TX_READY_I (tx_ready),
      .BUSY_O     (busy[g]),
      .OVERRUN_O  (overrun[g])
    );
  end

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame as a byte list) ----------------
  logic [7:0] m_bytes [NCFG][5];
  int         m_len   [NCFG];
  int         m_pos   [NCFG];
  bit         m_send  [NCFG];
  bit         m_gap   [NCFG];
  bit         m_ovr   [NCFG];
  bit         m_prev;

  function automatic logic [7:0] ref_byte(input int c, input logic [31:0] w, input int i);
    logic [7:0] b [4];
    int hdr;
    hdr = (c == 2) ? 1 : 0;
    if (c != 1) b = '{w[31:24], w[23:16], w[15:8], w[7:0]};
    else        b = '{w[7:0], w[15:8], w[23:16], w[31:24]};
    if (hdr == 1 && i == 0) return 8'hA5;
    return b[i - hdr];
  endfunction

  initial begin : model
    bit rise;
    m_prev = 1'b0;
    for (int c = 0; c < NCFG; c++) begin
      m_send[c] = 0; m_gap[c] = 0; m_ovr[c] = 0; m_pos[c] = 0;
      m_len[c]  = (c == 2) ? 5 : 4;
      for (int i = 0; i < 5; i++) m_bytes[c][i] = '0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_prev = 1'b0;
        for (int c = 0; c < NCFG; c++) begin
          m_send[c] = 0; m_gap[c] = 0; m_ovr[c] = 0; m_pos[c] = 0;
        end
      end else begin
        rise = mac_valid && !m_prev;
        for (int c = 0; c < NCFG; c++) begin
          if (rise && (m_send[c] || m_gap[c])) m_ovr[c] = 1;
          if (m_send[c]) begin
            if (tx_ready) begin
              m_pos[c]++;
              if (m_pos[c] == m_len[c]) begin
                m_send[c] = 0;
                m_gap[c]  = 1;
              end
            end
          end else if (m_gap[c]) begin
            m_gap[c] = 0;
          end else if (rise) begin
            for (int i = 0; i < m_len[c]; i++) m_bytes[c][i] = ref_byte(c, delta, i);
            m_pos[c]  = 0;
            m_send[c] = 1;
          end
        end
        m_prev = mac_valid;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("cyc_valid[%0d]", c), 40'(tx_valid[c]), 40'(m_send[c]));
      check($sformatf("cyc_busy[%0d]", c), 40'(busy[c]), 40'(m_send[c]));
      check($sformatf("cyc_ready[%0d]", c), 40'(mac_ready[c]), 40'(!m_send[c] && !m_gap[c]));
      check($sformatf("cyc_ovr[%0d]", c), 40'(overrun[c]), 40'(m_ovr[c]));
      if (!rst_n)
        check($sformatf("cyc_rst_data[%0d]", c), 40'(tx_data[c]), 40'h0);
      else if (m_send[c])
        check($sformatf("cyc_data[%0d]", c), 40'(tx_data[c]), 40'(m_bytes[c][m_pos[c]]));
    end
  end

  // Handshake log per configuration.
  logic [7:0] cap   [NCFG][16];
  int         cap_n [NCFG];

  initial forever begin
    @(negedge clk);
    for (int c = 0; c < NCFG; c++)
      if (rst_n && tx_valid[c] && tx_ready && cap_n[c] < 16) begin
        cap[c][cap_n[c]] = tx_data[c];
        cap_n[c]++;
      end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_caps();
    for (int c = 0; c < NCFG; c++) cap_n[c] = 0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (!(&mac_ready) && k < budget) begin
      tick();
      k++;
    end
    check("idle_wait", 40'(&mac_ready), 40'h1);
  endtask

  task automatic wait_cap(input int c, input int n, input int budget);
    int k;
    k = 0;
    while (cap_n[c] < n && k < budget) begin
      tick();
      k++;
    end
    check("cap_wait", 40'(cap_n[c] >= n), 40'h1);
  endtask

  task automatic check_frame(input string tag, input int c, input int n, input logic [39:0] exp);
    logic [39:0] e;
    e = exp;
    check({tag, "_len"}, 40'(cap_n[c]), 40'(n));
    for (int i = 0; i < n && i < cap_n[c]; i++)
      check($sformatf("%s_b%0d", tag, i), 40'(cap[c][i]), 40'(e[39-8*i -: 8]));
  endtask

  task automatic start_frame(input logic [31:0] d);
    mac_valid = 1'b0;
    tick();
    wait_idle(50);
    clear_caps();
    delta     = d;
    mac_valid = 1'b1;
  endtask

  typedef struct {
    int          cfg;
    logic [31:0] delta;
    logic [3:0]  rdy;   // ready pattern, bit 3 first
    int          n;
    logic [39:0] exp;   // expected bytes, first byte in [39:32]
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{0, 32'hBEC0_0000, 4'b1111, 4, 40'hBE_C0_00_00_00};
    vecs[1] = '{1, 32'h3E60_0000, 4'b1111, 4, 40'h00_00_60_3E_00};
    vecs[2] = '{2, 32'h3F80_0000, 4'b1001, 5, 40'hA5_3F_80_00_00};
    vecs[3] = '{0, 32'h7FC0_0001, 4'b1011, 4, 40'h7F_C0_00_01_00};
    vecs[4] = '{1, 32'h0000_0001, 4'b1101, 4, 40'h01_00_00_00_00};
    vecs[5] = '{2, 32'hFF80_0000, 4'b1111, 5, 40'hA5_FF_80_00_00};

    clear_caps();
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready",    40'(mac_ready), 40'h7);
    check("rst_valid",    40'(tx_valid),  40'h0);
    check("rst_busy",     40'(busy),      40'h0);
    check("rst_overrun",  40'(overrun),   40'h0);
    check("rst_data",     40'(tx_data),   40'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Table-driven frames, with DELTA_I changed right after capture.
    for (int v = 0; v < 6; v++) begin
      int k;
      tx_ready = 1'b1;
      start_frame(vecs[v].delta);
      k = 0;
      while (!(cap_n[vecs[v].cfg] == vecs[v].n && &mac_ready) && k < 80) begin
        tx_ready = vecs[v].rdy[3 - (k % 4)];
        tick();
        if (k == 0) delta = ~vecs[v].delta;
        k++;
      end
      tx_ready = 1'b1;
      wait_idle(20);
      check_frame($sformatf("vec%0d", v), vecs[v].cfg, vecs[v].n, vecs[v].exp);
      check($sformatf("vec%0d_ovr", v), 40'(overrun[vecs[v].cfg]), 40'h0);
    end

    // Level held high: exactly one capture, then a fresh edge.
    tx_ready = 1'b1;
    start_frame(32'h4000_0000);
    repeat (200) tick();
    check_frame("held", 0, 4, 40'h40_00_00_00_00);
    check("held_ovr", 40'(overrun[0]), 40'h0);
    start_frame(32'hC000_0000);
    wait_cap(0, 4, 20);
    wait_idle(20);
    check_frame("reedge", 0, 4, 40'hC0_00_00_00_00);

    // New edge mid-frame: dropped and flagged as overrun.
    start_frame(32'h1234_5678);
    wait_cap(0, 2, 20);
    tx_ready  = 1'b0;
    mac_valid = 1'b0;
    tick();
    delta     = 32'hFFFF_FFFF;
    mac_valid = 1'b1;
    repeat (3) tick();
    tx_ready = 1'b1;
    wait_cap(0, 4, 20);
    wait_idle(20);
    repeat (3) tick();
    check_frame("ovr", 0, 4, 40'h12_34_56_78_00);
    check("ovr_flag", 40'(overrun[0]), 40'h1);
    repeat (10) tick();
    check("ovr_sticky", 40'(overrun), 40'h7);

    // Asynchronous reset mid-frame, then a clean frame.
    start_frame(32'hA1B2_C3D4);
    wait_cap(0, 2, 20);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid",   40'(tx_valid),  40'h0);
    check("arst_busy",    40'(busy),      40'h0);
    check("arst_ready",   40'(mac_ready), 40'h7);
    check("arst_overrun", 40'(overrun),   40'h0);
    mac_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start_frame(32'h7F80_0000);
    wait_cap(0, 4, 20);
    wait_idle(20);
    check_frame("post_rst", 0, 4, 40'h7F_80_00_00_00);
    check("post_rst_ovr", 40'(overrun[0]), 40'h0);

    // Randomized traffic; the per-cycle model comparison does the checking.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) mac_valid = ~mac_valid;
      delta    = $urandom();
      tx_ready = ($urandom_range(0, 3) != 0);
      rst_n    = (i != 1000);
      tick();
    end
    rst_n     = 1'b1;
    tx_ready  = 1'b1;
    mac_valid = 1'b0;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
